// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and default dimensions for the MLP datapath
package mlp_pkg;
  localparam int MLP_IN_DIM    = 64;
  localparam int MLP_DATA_W    = 8;
  localparam int MLP_NUM_NODES = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_FIN
  } seq_state_t;
endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// rtl/mlp_layer_sequencer_if.sv - sequencer <-> hidden_node handshake and ROM row select
interface mlp_layer_sequencer_if import mlp_pkg::*; #(
  parameter int DATA_W    = MLP_DATA_W,
  parameter int NUM_NODES = MLP_NUM_NODES
);
  localparam int AW = $clog2(NUM_NODES);

  logic              node_start;
  logic              node_done;
  logic [DATA_W-1:0] node_out;
  logic [AW-1:0]     row_addr;

  modport master (output node_start, output row_addr, input node_done, input node_out);
  modport slave  (input node_start, input row_addr, output node_done, output node_out);
endinterface

// File: rtl/argmax_tracker.sv
// rtl/argmax_tracker.sv - running maximum of sampled values; ties keep the earliest index
module argmax_tracker #(
  parameter int DATA_W = 8,
  parameter int AW     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [DATA_W-1:0] din,
  input  logic [AW-1:0]     din_idx,
  output logic [AW-1:0]     best_idx
);
  logic [DATA_W-1:0] best_val_q, best_val_d;
  logic [AW-1:0]     best_idx_q, best_idx_d;

  always_comb begin
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    if (clear) begin
      best_val_d = '0;
      best_idx_d = '0;
    end else if (sample && (din > best_val_q)) begin
      best_val_d = din;
      best_idx_d = din_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign best_idx = best_idx_q;
endmodule

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - steps one shared hidden_node through a layer; MLP_SEQ_ARGMAX_EN adds one-hot argmax
module mlp_layer_sequencer import mlp_pkg::*; #(
  parameter int IN_DIM    = MLP_IN_DIM,
  parameter int DATA_W    = MLP_DATA_W,
  parameter int NUM_NODES = MLP_NUM_NODES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  mlp_layer_sequencer_if.master         node,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W*NUM_NODES-1:0]   act_vec,
  output logic [NUM_NODES-1:0]          class_onehot
);
  localparam int            AW   = $clog2(NUM_NODES);
  localparam logic [AW-1:0] LAST = AW'(NUM_NODES - 1);

  if (NUM_NODES < 2 || IN_DIM < 1) begin : g_bad_cfg
    $error("mlp_layer_sequencer: NUM_NODES must be >= 2 and IN_DIM >= 1");
  end

  seq_state_t                  state_q, state_d;
  logic [AW-1:0]               idx_q, idx_d;
  logic                        node_start_q, node_start_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [DATA_W*NUM_NODES-1:0] act_q, act_d;
  logic                        accept, capture, drain_exit, last_exit;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (node.node_done) state_d = S_DRAIN;
      // node_done lingers one cycle past the node's DONE state, so wait for it to fall
      S_DRAIN: if (!node.node_done) state_d = (idx_q == LAST) ? S_FIN : S_LOAD;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = (state_q == S_IDLE) && run;
    capture    = (state_q == S_WAIT) && node.node_done;
    drain_exit = (state_q == S_DRAIN) && !node.node_done;
    last_exit  = drain_exit && (idx_q == LAST);

    idx_d        = idx_q;
    act_d        = act_q;
    busy_d       = busy_q;
    node_start_d = (state_q == S_LOAD);
    done_d       = last_exit;

    if (accept) begin
      idx_d  = '0;
      act_d  = '0;
      busy_d = 1'b1;
    end
    if (capture) act_d[int'(idx_q)*DATA_W +: DATA_W] = node.node_out;
    if (drain_exit && !last_exit) idx_d = idx_q + 1'b1;
    if (state_q == S_FIN) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= '0;
      node_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      act_q        <= '0;
    end else begin
      idx_q        <= idx_d;
      node_start_q <= node_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      act_q        <= act_d;
    end
  end

  assign node.node_start = node_start_q;
  assign node.row_addr   = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign act_vec         = act_q;

`ifdef MLP_SEQ_ARGMAX_EN
  logic [AW-1:0]        best_idx;
  logic [NUM_NODES-1:0] class_q, class_d;

  argmax_tracker #(.DATA_W(DATA_W), .AW(AW)) u_argmax (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (accept),
    .sample   (capture),
    .din      (node.node_out),
    .din_idx  (idx_q),
    .best_idx (best_idx)
  );

  always_comb begin
    class_d = class_q;
    if (accept)         class_d = '0;
    else if (last_exit) class_d = {{(NUM_NODES-1){1'b0}}, 1'b1} << best_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) class_q <= '0;
    else        class_q <= class_d;
  end

  assign class_onehot = class_q;
`else
  assign class_onehot = '0;
`endif
endmodule
